// File: rtl/mc_table_loader_if.sv
// Table word stream feeding mc_table_loader.
// Master drives words, slave returns ready.
interface mc_table_loader_if;
   logic [17:0] iData;
   logic        iValid;
   logic        oReady;

   modport master (
      output iData,
      output iValid,
      input  oReady
   );

   modport slave (
      input  iData,
      input  iValid,
      output oReady
   );
endinterface

// File: rtl/mc_table_loader.sv
// Loads sigma then mu tables from a word stream, waits for the core,
// then flips the bank select and pulses start.
module mc_table_loader #(
   parameter int T         = 512,
   parameter int logT      = 9,
   parameter int pathWidth = 10
) (
   input  logic                 CLK,
   input  logic                 RST,
   mc_table_loader_if.slave     loadIf,
   input  logic                 iCoreDone,
   output logic [pathWidth-1:0] oSigmaWriteAddress,
   output logic [17:0]          oSigmaWriteData,
   output logic                 oSigmaWE,
   output logic [logT-1:0]      oMuWriteAddress,
   output logic [17:0]          oMuWriteData,
   output logic                 oMuWE,
   output logic                 oSwitch,
   output logic                 oStart
);

   typedef enum logic [1:0] {
      LOAD_SIGMA,
      LOAD_MU,
      WAIT_CORE,
      SWAP
   } state_t;

   state_t               stateQ;
   state_t               stateD;
   logic [pathWidth-1:0] sigmaCount;
   logic [logT-1:0]      muCount;
   logic                 coreIdle;
   logic                 accept;
   logic                 sigmaAccept;
   logic                 muAccept;
   logic                 sigmaLast;
   logic                 muLast;

   assign accept      = loadIf.iValid & loadIf.oReady;
   assign sigmaAccept = accept & (stateQ == LOAD_SIGMA);
   assign muAccept    = accept & (stateQ == LOAD_MU);
   assign sigmaLast   = &sigmaCount;
   assign muLast      = (muCount == logT'(T - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stateQ <= LOAD_SIGMA;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         LOAD_SIGMA: if (sigmaAccept && sigmaLast) stateD = LOAD_MU;
         LOAD_MU:    if (muAccept && muLast) stateD = WAIT_CORE;
         WAIT_CORE:  if (coreIdle) stateD = SWAP;
         SWAP:       stateD = LOAD_SIGMA;
         default:    stateD = LOAD_SIGMA;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sigmaCount         <= '0;
         muCount            <= '0;
         coreIdle           <= 1'b1;
         loadIf.oReady      <= 1'b0;
         oSigmaWriteAddress <= '0;
         oSigmaWriteData    <= '0;
         oSigmaWE           <= 1'b0;
         oMuWriteAddress    <= '0;
         oMuWriteData       <= '0;
         oMuWE              <= 1'b0;
         oSwitch            <= 1'b0;
         oStart             <= 1'b0;
      end else begin
         loadIf.oReady <= (stateD == LOAD_SIGMA) || (stateD == LOAD_MU);
         oSigmaWE      <= sigmaAccept;
         oMuWE         <= muAccept;
         oStart        <= (stateD == SWAP);
         oSwitch       <= oSwitch ^ (stateD == SWAP);
         if (sigmaAccept) begin
            oSigmaWriteAddress <= sigmaCount;
            oSigmaWriteData    <= loadIf.iData;
            sigmaCount         <= sigmaLast ? '0
                                  : sigmaCount + pathWidth'(1);
         end
         if (muAccept) begin
            oMuWriteAddress <= muCount;
            oMuWriteData    <= loadIf.iData;
            muCount         <= muLast ? '0 : muCount + logT'(1);
         end
         // A done pulse landing on the start cycle belongs to the old run.
         if (oStart) begin
            coreIdle <= 1'b0;
         end else if (iCoreDone) begin
            coreIdle <= 1'b1;
         end
      end
   end

endmodule
